rescale_ctrl: RTL and testbench
===============================

RESCALE_CTRL -- requirements
Module: rescale_ctrl

Interface
REQ-001 Parameter NUM_WIDTH, default 33: MAC/ADD number width on the upstream data path.
REQ-002 Parameter IMG_WIDTH, default 16: image data width on the downstream data path.
REQ-003 Parameter LATENCY, default 4: fixed latency in cycles from rs_data to rs_result of the controlled rescale datapath.
REQ-004 Parameter FIFO_DEPTH, default 8 (power of 2, greater than LATENCY): depth of the result buffer.
REQ-005 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port cfg_valid, input, 1: a configuration request is pending.
REQ-008 Port cfg_shift, input, 8: requested shift amount.
REQ-009 Port cfg_head, input, 8: requested head (saturation) bit index.
REQ-010 Port cfg_ready, output, 1: the configuration is accepted this cycle.
REQ-011 Port up_valid, input, 1, and port up_ready, output, 1: upstream handshake.
REQ-012 Port up_data, input, NUM_WIDTH: upstream number.
REQ-013 Port rs_shift, output, 8, and port rs_head, output, 8: configuration driven to the rescale datapath.
REQ-014 Port rs_data, output, NUM_WIDTH: number driven to the rescale datapath.
REQ-015 Port rs_result, input, IMG_WIDTH: rescaled result from the datapath, LATENCY cycles after rs_data.
REQ-016 Port dn_valid, output, 1; port dn_ready, input, 1; port dn_data, output, IMG_WIDTH: downstream handshake and data.
REQ-017 Port busy, output, 1: high while occ != 0.

Function
REQ-018 An upstream transfer (accept) SHALL occur on a cycle where up_valid and up_ready are both high; a downstream transfer SHALL occur on a cycle where dn_valid and dn_ready are both high.
REQ-019 rs_data SHALL equal up_data combinationally; the datapath captures it on every edge, and only accepted beats are tracked.
REQ-020 A LATENCY-bit valid shift register SHALL shift in the accept flag every cycle; when its last stage is 1, rs_result SHALL be written into the FIFO on that edge.
REQ-021 Counter occ, 0..FIFO_DEPTH, SHALL be +1 on accept, -1 on a downstream transfer, and unchanged when both or neither occur.
REQ-022 up_ready SHALL be (state==RUN) and (occ < FIFO_DEPTH), registered-free from state and occ; FIFO overflow is therefore impossible by construction.
REQ-023 dn_valid SHALL be FIFO not empty, and dn_data SHALL be the FIFO head, held stable while dn_valid is high and dn_ready is low.
REQ-024 FSM states:
- IDLE: up_ready=0; on cfg_valid, go to LOAD.
- RUN: on cfg_valid, go to DRAIN; otherwise stay in RUN.
- DRAIN: up_ready=0; when the valid shift register is all zero, go to LOAD.
- LOAD: cfg_ready=1 for exactly one cycle; rs_shift<=cfg_shift and rs_head<=cfg_head; go to RUN.
REQ-025 rs_shift and rs_head SHALL change only in LOAD, so the configuration is never altered while any accepted beat is inside the datapath.
REQ-026 Results already in the FIFO SHALL NOT block a reconfiguration; DRAIN waits only for in-flight beats.
REQ-027 Ordering SHALL be preserved: dn_data order equals accept order.
REQ-028 With dn_ready held high in RUN, the block SHALL sustain one accept per cycle indefinitely.
REQ-029 Latency from accept to dn_valid SHALL be LATENCY+1 cycles when the FIFO is empty.
REQ-030 A cfg_valid arriving on the same cycle as an accept SHALL let that beat complete under the old configuration.

Reset
REQ-031 While rst is high, and immediately on its assertion: state=IDLE, valid shift register=0, FIFO empty, occ=0, rs_shift=0, rs_head=0, cfg_ready=0, up_ready=0, dn_valid=0, busy=0.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight and buffered beats with no downstream transfer; after release, the block requires a new configuration.

Verification
REQ-033 After reset, raise cfg_valid with shift=4, head=15 -> cfg_ready pulses one cycle later, rs_shift=4, rs_head=15, and up_ready=1 in the following cycle.
REQ-034 Stream 20 accepts back-to-back with dn_ready=1 and a model datapath -> 20 results in order, the first dn_valid 5 cycles after the first accept, and no up_ready gaps.
REQ-035 Hold dn_ready=0 and stream data -> exactly 8 accepts, after which up_ready=0; release dn_ready -> 8 results in order, no loss, and occ returns to 0.
REQ-036 With 3 beats in flight, assert cfg_valid with shift=2 -> up_ready drops, those 3 results are produced with shift=4, cfg_ready pulses only after the valid shift register clears, and rs_shift=2.
REQ-037 Assert rst with 5 beats buffered -> dn_valid=0, busy=0, and state=IDLE immediately; no stale beat appears after reconfiguration.

Source files
------------

// File: rtl/rescale_ctrl.sv
// Sequencing controller for a fixed-latency rescale datapath: tracks accepted
// beats through the pipe, buffers results in a FIFO and gates reconfiguration.
module rescale_ctrl #(
  parameter int unsigned NUM_WIDTH  = 33,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic [7:0]           cfg_shift,
  input  logic [7:0]           cfg_head,
  output logic                 cfg_ready,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [NUM_WIDTH-1:0] up_data,
  output logic [7:0]           rs_shift,
  output logic [7:0]           rs_head,
  output logic [NUM_WIDTH-1:0] rs_data,
  input  logic [IMG_WIDTH-1:0] rs_result,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [IMG_WIDTH-1:0] dn_data,
  output logic                 busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    LOAD  = 2'd3
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [LATENCY-1:0]   vld_sr;
  logic [CNT_W-1:0]     occ;
  logic [CNT_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     rd_ptr;
  logic [IMG_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                 accept;
  logic                 deliver;
  logic                 fifo_wr;
  logic                 fifo_empty;

  assign accept     = up_valid & up_ready;
  assign deliver    = dn_valid & dn_ready;
  assign fifo_wr    = vld_sr[LATENCY-1];
  assign fifo_empty = (wr_ptr == rd_ptr);

  // occ counts in-flight plus buffered beats, so gating on it bounds the FIFO
  assign up_ready = (state == RUN) && (occ < CNT_W'(FIFO_DEPTH));
  assign dn_valid = !fifo_empty;
  assign dn_data  = mem[rd_ptr[PTR_W-1:0]];
  assign busy     = (occ != '0);
  assign rs_data  = up_data;

  // State register and configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cfg_ready <= 1'b0;
      rs_shift  <= '0;
      rs_head   <= '0;
    end else begin
      state     <= state_next;
      cfg_ready <= (state_next == LOAD);
      if (state == LOAD) begin
        rs_shift <= cfg_shift;
        rs_head  <= cfg_head;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_valid) state_next = LOAD;
      RUN:     if (cfg_valid) state_next = DRAIN;
      DRAIN:   if (vld_sr == '0) state_next = LOAD;
      LOAD:    state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Valid tracking, occupancy and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      occ    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      vld_sr <= LATENCY'({vld_sr, accept});
      case ({accept, deliver})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      if (fifo_wr) wr_ptr <= wr_ptr + CNT_W'(1);
      if (deliver) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Result storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr[PTR_W-1:0]] <= rs_result;
  end

endmodule

// File: tb/tb_rescale_ctrl.sv
// Directed + randomized bench for rescale_ctrl with a model rescale datapath
// and a queue-based scoreboard of expected results.
module tb_rescale_ctrl;

  localparam int unsigned NW  = 33;
  localparam int unsigned IW  = 16;
  localparam int unsigned LAT = 4;
  localparam int unsigned DEP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [7:0]    cfg_shift;
  logic [7:0]    cfg_head;
  logic          cfg_ready;
  logic          up_valid;
  logic          up_ready;
  logic [NW-1:0] up_data;
  logic [7:0]    rs_shift;
  logic [7:0]    rs_head;
  logic [NW-1:0] rs_data;
  logic [IW-1:0] rs_result;
  logic          dn_valid;
  logic          dn_ready;
  logic [IW-1:0] dn_data;
  logic          busy;

  rescale_ctrl #(.NUM_WIDTH(NW), .IMG_WIDTH(IW), .LATENCY(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_shift(cfg_shift), .cfg_head(cfg_head), .cfg_ready(cfg_ready),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .rs_shift(rs_shift), .rs_head(rs_head), .rs_data(rs_data), .rs_result(rs_result),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift right then saturate to the head bit index
  function automatic logic [IW-1:0] ref_rescale(input logic [NW-1:0] d, input int s, input int h);
    longint unsigned v;
    longint unsigned lim;
    v   = 64'(d) >> s;
    lim = (64'd1 << (h + 1)) - 64'd1;
    if (v > lim) v = lim;
    return IW'(v);
  endfunction

  // Stand-in datapath: fixed LAT-cycle pipe of the rescale function
  logic [IW-1:0] dp [LAT];
  always @(posedge clk) begin
    dp[0] <= ref_rescale(rs_data, int'(rs_shift), int'(rs_head));
    for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
  end
  assign rs_result = dp[LAT-1];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_dn = 0;
  int first_acc = -1;
  int first_dnv = -1;
  int m_shift = 0;
  int m_head = 0;
  logic [IW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: record the transfers the coming edge will perform, then advance
  task automatic tick();
    #1;
    cyc++;
    if (up_valid && up_ready) begin
      exp_q.push_back(ref_rescale(up_data, m_shift, m_head));
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (dn_valid && first_dnv < 0) first_dnv = cyc;
    if (dn_valid && dn_ready) begin
      n_dn++;
      chk("dn_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) chk("dn_data", 64'(dn_data), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    up_valid = 1'b0;
    dn_ready = 1'b1;
    while ((exp_q.size() != 0 || dn_valid) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic configure(input int s, input int h, output int n);
    cfg_valid = 1'b1;
    cfg_shift = 8'(s);
    cfg_head  = 8'(h);
    n = 0;
    while (!cfg_ready && n < 100) begin
      tick();
      up_valid = 1'b0;
      n++;
    end
    chk("cfg_timeout", 64'(n < 100), 64'd1);
    m_shift = s;
    m_head  = h;
    tick();
    cfg_valid = 1'b0;
  endtask

  function automatic logic [NW-1:0] rand_num();
    return NW'({$urandom, $urandom}) >> $urandom_range(0, 20);
  endfunction

  initial begin
    int n;
    int a0;
    int d0;
    int gaps;
    int sent;
    logic [IW-1:0] held;

    rst = 1'b1; cfg_valid = 1'b0; cfg_shift = '0; cfg_head = '0;
    up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst_up_ready", 64'(up_ready), 64'd0);
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rs_shift", 64'(rs_shift), 64'd0);
    chk("rst_rs_head", 64'(rs_head), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_up_ready", 64'(up_ready), 64'd0);

    // First configuration
    configure(4, 15, n);
    chk("cfg1_latency", 64'(n), 64'd1);
    chk("cfg1_pulse_once", 64'(cfg_ready), 64'd0);
    chk("cfg1_rs_shift", 64'(rs_shift), 64'd4);
    chk("cfg1_rs_head", 64'(rs_head), 64'd15);
    chk("cfg1_up_ready", 64'(up_ready), 64'd1);

    // Back-to-back stream with an always-ready sink
    dn_ready = 1'b1;
    first_acc = -1; first_dnv = -1; gaps = 0;
    a0 = n_acc; d0 = n_dn;
    for (int i = 0; i < 20; i++) begin
      up_valid = 1'b1;
      up_data  = rand_num();
      if (!up_ready) gaps++;
      tick();
    end
    drain();
    chk("s1_no_gaps", 64'(gaps), 64'd0);
    chk("s1_accepts", 64'(n_acc - a0), 64'd20);
    chk("s1_results", 64'(n_dn - d0), 64'd20);
    chk("s1_first_latency", 64'(first_dnv - first_acc), 64'(LAT + 1));

    // Backpressure fills the buffer to exactly its depth
    dn_ready = 1'b0;
    a0 = n_acc; d0 = n_dn;
    for (int i = 0; i < 20; i++) begin
      up_valid = 1'b1;
      up_data  = rand_num();
      tick();
    end
    chk("bp_accepts", 64'(n_acc - a0), 64'(DEP));
    chk("bp_up_ready", 64'(up_ready), 64'd0);
    chk("bp_busy", 64'(busy), 64'd1);
    held = dn_data;
    tick();
    chk("bp_dn_valid", 64'(dn_valid), 64'd1);
    chk("bp_dn_stable", 64'(dn_data), 64'(held));
    drain();
    chk("bp_results", 64'(n_dn - d0), 64'(DEP));
    chk("bp_busy_clear", 64'(busy), 64'd0);

    // Reconfigure with beats in flight; last beat accepted alongside cfg_valid
    dn_ready = 1'b1;
    a0 = n_acc; d0 = n_dn;
    for (int i = 0; i < 2; i++) begin
      up_valid = 1'b1;
      up_data  = NW'($urandom_range(0, 262143));
      tick();
    end
    up_data   = NW'($urandom_range(0, 262143));
    cfg_valid = 1'b1;
    cfg_shift = 8'd2;
    cfg_head  = 8'd15;
    tick();
    up_valid = 1'b0;
    n = 1;
    chk("rc_up_ready_drop", 64'(up_ready), 64'd0);
    chk("rc_accepts", 64'(n_acc - a0), 64'd3);
    while (!cfg_ready && n < 100) begin
      chk("rc_hold_shift", 64'(rs_shift), 64'd4);
      tick();
      n++;
    end
    chk("rc_cfg_latency", 64'(n), 64'(LAT + 2));
    chk("rc_old_results", 64'(n_dn - d0), 64'd3);
    m_shift = 2;
    tick();
    cfg_valid = 1'b0;
    chk("rc_rs_shift", 64'(rs_shift), 64'd2);
    chk("rc_up_ready", 64'(up_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      up_valid = 1'b1;
      up_data  = NW'($urandom_range(0, 262143));
      tick();
    end
    drain();

    // Reset with beats buffered discards everything
    dn_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_valid = 1'b1;
      up_data  = rand_num();
      tick();
    end
    up_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) tick();
    chk("pre_rst_dn_valid", 64'(dn_valid), 64'd1);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_dn_valid", 64'(dn_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_up_ready", 64'(up_ready), 64'd0);
    chk("arst_rs_shift", 64'(rs_shift), 64'd0);
    exp_q.delete();
    m_shift = 0; m_head = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dn_ready = 1'b1;
    up_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 4; i++) tick();
    up_valid = 1'b0;
    chk("post_rst_no_accept", 64'(n_acc - a0), 64'd0);
    chk("post_rst_dn_valid", 64'(dn_valid), 64'd0);
    configure(4, 15, n);
    chk("cfg2_latency", 64'(n), 64'd1);
    d0 = n_dn;
    for (int i = 0; i < 10; i++) tick();
    chk("no_stale", 64'(n_dn - d0), 64'd0);

    // Random valid/ready traffic
    a0 = n_acc; d0 = n_dn; sent = 0; n = 0;
    while (n_acc - a0 < 12 && n < 300) begin
      up_valid = 1'($urandom);
      up_data  = rand_num();
      dn_ready = 1'($urandom);
      tick();
      n++;
    end
    drain();
    sent = n_acc - a0;
    chk("rand_accepts", 64'(sent), 64'd12);
    chk("rand_results", 64'(n_dn - d0), 64'(sent));
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
